// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh edge terminals: packet header layout,
// receive FSM states and a saturating counter helper.
package mesh_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ID_W       = 4;
  localparam int HDR_W      = NXT_JUMP_W + 2 * ID_W + 1;

  typedef enum logic [1:0] {IDLE, POP, GAP} term_rx_state_t;

  typedef struct packed {
    logic [NXT_JUMP_W-1:0] nxt_jump;
    logic [ID_W-1:0]       id_row;
    logic [ID_W-1:0]       id_col;
    logic                  mode;
  } mesh_hdr_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Small synchronous FIFO for the terminal receive buffer; the head entry is
// read straight from the storage registers so it never depends on the pop input.
module mesh_term_fifo #(
  parameter int width = 41,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/mesh_terminal_rx.sv
// Receive-side terminal for one mesh edge port: drains the mesh output FIFO,
// flags misrouted packets and buffers them for a valid/ready host.
module mesh_terminal_rx
  import mesh_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1,
  parameter logic [pckg_sz-18:0] bdcst = {1'b0, {(pckg_sz-18){1'b1}}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic [pckg_sz-1:0] host_data,
  output logic               host_misroute,
  output logic               host_valid,
  input  logic               host_ready,
  output logic [15:0]        rx_count,
  output logic [15:0]        err_count
);

  localparam int PAY_W = pckg_sz - 17;
  // Terminal ids live on the (ROWS+2) x (COLUMS+2) ring around the mesh.
  localparam logic [ID_W-1:0] SELF_ROW_ID = ID_W'(SELF_ROW % (ROWS + 2));
  localparam logic [ID_W-1:0] SELF_COL_ID = ID_W'(SELF_COL % (COLUMS + 2));

  term_rx_state_t     state;
  mesh_hdr_t          hdr;
  logic [PAY_W-1:0]   payload;
  logic               misroute;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;
  logic [pckg_sz:0]   fifo_head;
  logic               unused_hdr_bits;

  assign hdr             = data_out[pckg_sz-1 -: HDR_W];
  assign payload         = data_out[PAY_W-1:0];
  assign unused_hdr_bits = ^{hdr.nxt_jump, hdr.mode};
  assign misroute        = !(hdr.id_row == SELF_ROW_ID && hdr.id_col == SELF_COL_ID)
                           && (payload != bdcst);
  assign capture         = (state == POP);

  // Capture sequencer; the GAP state gives the mesh port a cycle to
  // present its next head packet after the dequeue strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pndng && !fifo_full) begin
            state <= POP;
            pop   <= 1'b1;
          end
        end
        POP: begin
          state <= GAP;
          pop   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          pop   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count  <= '0;
      err_count <= '0;
    end else if (capture) begin
      rx_count <= sat_inc(rx_count);
      if (misroute) err_count <= sat_inc(err_count);
    end
  end

  mesh_term_fifo #(
    .width (pckg_sz + 1),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data ({misroute, data_out}),
    .pop       (host_valid && host_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign host_valid    = !fifo_empty;
  assign host_data     = fifo_head[pckg_sz-1:0];
  assign host_misroute = fifo_head[pckg_sz];

endmodule

// File: tb/tb_mesh_terminal_rx.sv
// Randomized and directed bench for mesh_terminal_rx, checked against a
// queue-based model of the mesh port and the terminal's delivery stream.
module tb_mesh_terminal_rx;

  localparam int PCKG_SZ = 40;
  localparam int DEPTH   = 4;
  localparam int PAY_W   = 23;
  localparam logic [PAY_W-1:0] BDCST = 23'h3FFFFF;

  logic               clk = 1'b0;
  logic               reset;
  logic               pndng;
  logic [PCKG_SZ-1:0] data_out;
  logic               pop;
  logic [PCKG_SZ-1:0] host_data;
  logic               host_misroute;
  logic               host_valid;
  logic               host_ready;
  logic [15:0]        rx_count;
  logic [15:0]        err_count;

  int checks   = 0;
  int failures = 0;

  logic [PCKG_SZ-1:0] mesh_q[$];
  logic [PCKG_SZ:0]   exp_q[$];
  logic [PCKG_SZ-1:0] deliv_log[$];
  logic [15:0]        exp_rx;
  logic [15:0]        exp_err;
  int                 pop_seen = 0;
  int                 delivered = 0;
  int                 cycle_no = 0;
  int                 last_pop_cycle = -1;
  bit                 exact_gap = 0;

  always #5 clk = ~clk;

  mesh_terminal_rx #(
    .pckg_sz    (PCKG_SZ),
    .fifo_depth (DEPTH),
    .ROWS       (4),
    .COLUMS     (4),
    .SELF_ROW   (0),
    .SELF_COL   (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pndng         (pndng),
    .data_out      (data_out),
    .pop           (pop),
    .host_data     (host_data),
    .host_misroute (host_misroute),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .rx_count      (rx_count),
    .err_count     (err_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic model_misroute(input logic [PCKG_SZ-1:0] p);
    logic [3:0]       row;
    logic [3:0]       col;
    logic [PAY_W-1:0] pay;
    row = p[31:28];
    col = p[27:24];
    pay = p[22:0];
    return !(row == 4'd0 && col == 4'd1) && (pay != BDCST);
  endfunction

  function automatic logic [PCKG_SZ-1:0] make_pkt(input logic [3:0] row, input logic [3:0] col,
                                                  input logic [PAY_W-1:0] pay);
    logic [7:0] jump;
    logic       mode;
    jump = 8'($urandom);
    mode = 1'($urandom);
    return {jump, row, col, mode, pay};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic driveMesh();
    pndng    = (mesh_q.size() > 0);
    data_out = (mesh_q.size() > 0) ? mesh_q[0] : '0;
  endtask

  task automatic modelReset();
    exp_q.delete();
    exp_rx         = 16'd0;
    exp_err        = 16'd0;
    last_pop_cycle = -1;
  endtask

  // Advance n clock cycles, updating the model and checking the outputs.
  task automatic applyStimulus(input int n);
    logic               pop_now;
    logic               hr_now;
    logic               hv_now;
    logic [PCKG_SZ-1:0] hd_now;
    logic [PCKG_SZ-1:0] pkt;
    logic               mis;
    int                 occ_before;
    repeat (n) begin
      pop_now    = pop;
      hr_now     = host_ready;
      hv_now     = host_valid;
      hd_now     = host_data;
      occ_before = exp_q.size();
      @(posedge clk);
      #1;
      cycle_no++;
      if (hv_now && hr_now) begin
        if (exp_q.size() == 0) checkOutput("deliver_underflow", 1, 0);
        else begin
          void'(exp_q.pop_front());
          deliv_log.push_back(hd_now);
          delivered++;
        end
      end
      if (pop_now) begin
        checkOutput("pop_has_pkt", mesh_q.size() > 0, 1);
        checkOutput("pop_has_space", occ_before < DEPTH, 1);
        if (last_pop_cycle >= 0) begin
          if (exact_gap) checkOutput("pop_gap_exact", cycle_no - last_pop_cycle, 3);
          else checkOutput("pop_gap_min", (cycle_no - last_pop_cycle) >= 3, 1);
        end
        last_pop_cycle = cycle_no;
        pop_seen++;
        if (mesh_q.size() > 0) begin
          pkt = mesh_q.pop_front();
          mis = model_misroute(pkt);
          exp_q.push_back({mis, pkt});
          exp_rx = sat_add(exp_rx);
          if (mis) exp_err = sat_add(exp_err);
        end
      end
      driveMesh();
      checkOutput("host_valid", host_valid, exp_q.size() > 0);
      checkOutput("rx_count", rx_count, exp_rx);
      checkOutput("err_count", err_count, exp_err);
      if (exp_q.size() > 0) begin
        checkOutput("host_data", host_data, exp_q[0][PCKG_SZ-1:0]);
        checkOutput("host_misroute", host_misroute, exp_q[0][PCKG_SZ]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PCKG_SZ-1:0] pkt_a;
    logic [PCKG_SZ-1:0] sent[$];
    logic [PCKG_SZ-1:0] head_pkt;
    int p0;
    int d0;
    logic [15:0] rx0;
    bit got_pop;

    reset      = 1'b0;
    pndng      = 1'b0;
    data_out   = '0;
    host_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pop", pop, 0);
    checkOutput("rst_host_valid", host_valid, 0);
    checkOutput("rst_host_data", host_data, 0);
    checkOutput("rst_host_misroute", host_misroute, 0);
    checkOutput("rst_rx_count", rx_count, 0);
    checkOutput("rst_err_count", err_count, 0);
    reset = 1'b1;
    applyStimulus(2);

    // Correctly addressed packet: one pop, delivered with latency of two edges.
    pkt_a = make_pkt(4'd0, 4'd1, 23'd5);
    mesh_q.push_back(pkt_a);
    driveMesh();
    p0 = pop_seen;
    applyStimulus(1);
    checkOutput("t1_pop_latency", pop, 1);
    checkOutput("t1_valid_early", host_valid, 0);
    applyStimulus(1);
    checkOutput("t1_valid", host_valid, 1);
    checkOutput("t1_rx", rx_count, 16'd1);
    applyStimulus(3);
    checkOutput("t1_pops", pop_seen - p0, 1);
    checkOutput("t1_data", host_data, pkt_a);
    checkOutput("t1_misroute", host_misroute, 0);
    checkOutput("t1_err", err_count, 16'd0);
    host_ready = 1'b1;
    applyStimulus(2);
    host_ready = 1'b0;

    // Misrouted unicast, then a broadcast to the same wrong coordinates.
    mesh_q.push_back(make_pkt(4'd2, 4'd3, 23'd7));
    driveMesh();
    applyStimulus(4);
    checkOutput("t2_misroute", host_misroute, 1);
    checkOutput("t2_err", err_count, 16'd1);
    host_ready = 1'b1;
    applyStimulus(1);
    host_ready = 1'b0;
    mesh_q.push_back(make_pkt(4'd2, 4'd3, BDCST));
    driveMesh();
    applyStimulus(4);
    checkOutput("t2_bdcst_misroute", host_misroute, 0);
    checkOutput("t2_bdcst_err", err_count, 16'd1);
    host_ready = 1'b1;
    applyStimulus(2);
    host_ready = 1'b0;

    // Backpressure: only DEPTH packets are drained until the host reads.
    sent.delete();
    deliv_log.delete();
    for (int i = 0; i < 6; i++) begin
      sent.push_back(make_pkt(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 23'($urandom)));
      mesh_q.push_back(sent[i]);
    end
    driveMesh();
    p0 = pop_seen;
    d0 = delivered;
    applyStimulus(30);
    checkOutput("t3_pops_full", pop_seen - p0, 4);
    checkOutput("t3_pop_idle", pop, 0);
    checkOutput("t3_mesh_left", mesh_q.size(), 2);
    host_ready = 1'b1;
    applyStimulus(30);
    checkOutput("t3_pops_total", pop_seen - p0, 6);
    checkOutput("t3_delivered", delivered - d0, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < deliv_log.size()) checkOutput("t3_order", deliv_log[i], sent[i]);
      else checkOutput("t3_order_missing", 0, 1);
    end

    // Continuous supply: one capture every three cycles.
    for (int c = 0; c < 40; c++) begin
      if (mesh_q.size() < 3) mesh_q.push_back(make_pkt(4'd0, 4'd1, 23'($urandom)));
      driveMesh();
      if (c == 10) begin
        p0 = pop_seen;
        rx0 = rx_count;
        exact_gap = 1;
      end
      applyStimulus(1);
    end
    exact_gap = 0;
    checkOutput("t4_pops_30cyc", pop_seen - p0, 10);
    checkOutput("t4_rx_30cyc", rx_count - rx0, 16'd10);

    // Reset while the dequeue strobe is high.
    got_pop = 0;
    for (int c = 0; c < 10 && !got_pop; c++) begin
      if (mesh_q.size() < 2) mesh_q.push_back(make_pkt(4'd0, 4'd1, 23'($urandom)));
      driveMesh();
      applyStimulus(1);
      if (pop) got_pop = 1;
    end
    checkOutput("t5_wait_pop", got_pop, 1);
    reset = 1'b0;
    #1;
    checkOutput("t5_pop_async", pop, 0);
    modelReset();
    applyStimulus(2);
    reset = 1'b1;
    host_ready = 1'b0;
    checkOutput("t5_rx_after", rx_count, 16'd0);
    checkOutput("t5_valid_after", host_valid, 0);
    head_pkt = mesh_q[0];
    applyStimulus(4);
    checkOutput("t5_rx_next", rx_count, 16'd1);
    checkOutput("t5_data_next", host_data, head_pkt);

    // Counter saturation from a preloaded near-full value.
    host_ready = 1'b1;
    for (int c = 0; c < 40 && (mesh_q.size() > 0 || exp_q.size() > 0); c++) applyStimulus(1);
    applyStimulus(3);
    force dut.rx_count  = 16'hFFFE;
    force dut.err_count = 16'hFFFE;
    #1;
    release dut.rx_count;
    release dut.err_count;
    exp_rx  = 16'hFFFE;
    exp_err = 16'hFFFE;
    for (int i = 0; i < 3; i++) mesh_q.push_back(make_pkt(4'd3, 4'd3, 23'(i + 1)));
    driveMesh();
    applyStimulus(15);
    checkOutput("t6_rx_sat", rx_count, 16'hFFFF);
    checkOutput("t6_err_sat", err_count, 16'hFFFF);

    // Randomized traffic and host backpressure.
    reset = 1'b0;
    #1;
    modelReset();
    applyStimulus(1);
    reset = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 40 && mesh_q.size() < 8) begin
        mesh_q.push_back(make_pkt(4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                                  ($urandom_range(0, 3) == 0) ? BDCST : 23'($urandom)));
      end
      host_ready = ($urandom_range(0, 99) < 60);
      driveMesh();
      applyStimulus(1);
    end
    host_ready = 1'b1;
    applyStimulus(40);
    checkOutput("t7_mesh_drained", mesh_q.size(), 0);
    checkOutput("t7_fifo_drained", host_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
